jtframe_sdram_mux: RTL and testbench
====================================

JTFRAME_SDRAM_MUX -- requirements
Module: jtframe_sdram_mux

Interface
REQ-001 Parameter SLOTn_AW (n=0..9), default 22: width of the slot n address, in 16-bit words, with 1 <= SLOTn_AW <= 22.
REQ-002 Parameter SLOTn_DW (n=0..9), default 16: width of the slot n data, 16 or 32 only.
REQ-003 clk, input, 1: single system clock; all logic on its rising edge.
REQ-004 rst, input, 1: asynchronous, active-low reset.
REQ-005 vblank, input, 1: video blanking; arbitration is not affected by it.
REQ-006 slotn_offset, input, 22: per-slot base word address in SDRAM (n=0..9).
REQ-007 slotn_addr, input, SLOTn_AW: per-slot word address relative to its offset.
REQ-008 slotn_dout, output, SLOTn_DW: per-slot read data.
REQ-009 slot0_din and slot1_din, input, 16: write data; only slots 0 and 1 can write.
REQ-010 slot_cs, input, 10: per-slot access request, held until slot_ok.
REQ-011 slot_ok, output, 10: per-slot data valid / write done.
REQ-012 slot_wr, input, 10: per-slot write strobe; bits 9..2 are ignored.
REQ-013 downloading and loop_rst, input, 1 each: ROM download in progress and synchronous restart.
REQ-014 sdram_req, output, 1: request to the SDRAM controller; sdram_ack, input, 1: request accepted.
REQ-015 sdram_addr, output, 22: SDRAM word address.
REQ-016 sdram_rnw, output, 1: 1 = read, 0 = write.
REQ-017 data_rdy, input, 1: read data valid or write completed.
REQ-018 data_read, input, 32: {word addr+1, word addr}.
REQ-019 data_write, output, 32: write data.
REQ-020 refresh_en, output, 1: controller may refresh.

Function
REQ-021 The access address SHALL be slotn_offset + zero-extended slotn_addr, mod 2^22.
REQ-022 FSM states SHALL be IDLE, WAIT_ACK and WAIT_DATA.
  - IDLE -> WAIT_ACK when a slot is pending.
  - WAIT_ACK -> WAIT_DATA on sdram_ack.
  - WAIT_DATA -> IDLE on data_rdy.
REQ-023 A slot is pending when all of the following hold: its cs is 1, its slot_ok is 0, downloading is 0.
REQ-024 Arbitration SHALL be fixed priority, lowest slot index first, sampled only in IDLE; exactly one access is outstanding at a time.
REQ-025 On grant, the block SHALL register sdram_addr and sdram_rnw (~slot_wr[n]) and, for a write, data_write = {din,din}, then raise sdram_req the next cycle.
REQ-026 sdram_req SHALL remain high through WAIT_ACK and drop in the cycle after sdram_ack is seen.
REQ-027 data_rdy SHALL be ignored outside WAIT_DATA.
REQ-028 On data_rdy in WAIT_DATA, for a read the granted slot's dout SHALL latch data_read[15:0] when DW=16, or data_read[31:0] when DW=32.
REQ-029 The granted slot's slot_ok SHALL rise on the next cycle.
REQ-030 Each slot SHALL keep a one-entry cache: last completed address plus a valid bit.
REQ-031 slot_ok[n] SHALL be high only while cs[n]=1, the valid bit is set and slotn_addr equals the cached address.
REQ-032 A cache hit SHALL produce slot_ok with no SDRAM access; a changed address SHALL drop slot_ok in the same cycle (combinational compare).
REQ-033 A write SHALL invalidate the read cache of every slot, then set slot_ok for the writer.
REQ-034 cs falling mid-access SHALL NOT abort the access; the data is still cached.
REQ-035 refresh_en SHALL be 1 only in IDLE with no pending slot and downloading=0.
REQ-036 While downloading=1, no new grant SHALL be issued, all slot_ok SHALL be 0, and an outstanding access SHALL complete.
REQ-037 loop_rst=1 SHALL, synchronously:
  - return the FSM to IDLE;
  - clear all valid bits and sdram_req.

Reset
REQ-038 While rst=0 the block SHALL hold these values:
  - FSM in IDLE;
  - sdram_req=0, sdram_rnw=1, sdram_addr=0;
  - data_write=0, refresh_en=0;
  - slot_ok=0, all dout=0, all valid bits cleared.
REQ-039 Normal operation SHALL resume on the first rising clk edge after rst rises.

Verification
REQ-040 Slot 3 read: AW=18, offset 0x320000, addr 0x00010, cs=1, memory word 0x320010=0xBEEF.
  - sdram_addr SHALL be 0x320010 and slot3_dout SHALL be 0xBEEF.
  - slot_ok[3] SHALL rise 1 cycle after data_rdy.
REQ-041 Cache hit: same slot 3 address again, with cs toggled low then high.
  - slot_ok[3] SHALL be high the same cycle; sdram_req SHALL stay 0.
REQ-042 Slots 6 and 2 request in the same cycle (DW=32, offset 0x100000).
  - Slot 2 SHALL be served first.
  - slot2_dout SHALL equal {mem[a+1],mem[a]}.
REQ-043 Slot 0 write, din=0x1234, address 0x000005.
  - sdram_rnw SHALL be 0 and data_write SHALL be 0x12341234.
  - A following slot 3 cached read SHALL re-issue an SDRAM access.
REQ-044 downloading=1 with cs=0x3F8 asserted.
  - sdram_req SHALL stay 0 and slot_ok SHALL be 0.
  - Requests SHALL resume after downloading falls.
REQ-045 rst asserted during WAIT_DATA.
  - All outputs SHALL take the REQ-038 values immediately.
  - A data_rdy arriving later SHALL be ignored.

Source files
------------

// File: rtl/jtframe_sdram_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_sdram_mux_if
// Brief    : Request/response bus between the slot mux and the SDRAM controller
// Revision : 1.0
// ============================================================================
interface jtframe_sdram_mux_if;
    logic        sdram_req;
    logic        sdram_ack;
    logic [21:0] sdram_addr;
    logic        sdram_rnw;
    logic        data_rdy;
    logic [31:0] data_read;
    logic [31:0] data_write;
    logic        refresh_en;

    modport master (
        output sdram_req, sdram_addr, sdram_rnw, data_write, refresh_en,
        input  sdram_ack, data_rdy, data_read
    );

    modport slave (
        input  sdram_req, sdram_addr, sdram_rnw, data_write, refresh_en,
        output sdram_ack, data_rdy, data_read
    );
endinterface
`default_nettype wire

// File: rtl/jtframe_sdram_mux.sv
`default_nettype none
// ============================================================================
// Module   : jtframe_sdram_mux
// Brief    : Ten-slot fixed-priority SDRAM arbiter with a one-entry cache per slot
// Revision : 1.0
// ============================================================================
module jtframe_sdram_mux #(
    parameter int SLOT0_AW = 22, parameter int SLOT1_AW = 22,
    parameter int SLOT2_AW = 22, parameter int SLOT3_AW = 22,
    parameter int SLOT4_AW = 22, parameter int SLOT5_AW = 22,
    parameter int SLOT6_AW = 22, parameter int SLOT7_AW = 22,
    parameter int SLOT8_AW = 22, parameter int SLOT9_AW = 22,
    parameter int SLOT0_DW = 16, parameter int SLOT1_DW = 16,
    parameter int SLOT2_DW = 16, parameter int SLOT3_DW = 16,
    parameter int SLOT4_DW = 16, parameter int SLOT5_DW = 16,
    parameter int SLOT6_DW = 16, parameter int SLOT7_DW = 16,
    parameter int SLOT8_DW = 16, parameter int SLOT9_DW = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vblank,
    input  logic                downloading,
    input  logic                loop_rst,
    input  logic [21:0]         slot0_offset, slot1_offset, slot2_offset, slot3_offset,
    input  logic [21:0]         slot4_offset, slot5_offset, slot6_offset, slot7_offset,
    input  logic [21:0]         slot8_offset, slot9_offset,
    input  logic [SLOT0_AW-1:0] slot0_addr,
    input  logic [SLOT1_AW-1:0] slot1_addr,
    input  logic [SLOT2_AW-1:0] slot2_addr,
    input  logic [SLOT3_AW-1:0] slot3_addr,
    input  logic [SLOT4_AW-1:0] slot4_addr,
    input  logic [SLOT5_AW-1:0] slot5_addr,
    input  logic [SLOT6_AW-1:0] slot6_addr,
    input  logic [SLOT7_AW-1:0] slot7_addr,
    input  logic [SLOT8_AW-1:0] slot8_addr,
    input  logic [SLOT9_AW-1:0] slot9_addr,
    output logic [SLOT0_DW-1:0] slot0_dout,
    output logic [SLOT1_DW-1:0] slot1_dout,
    output logic [SLOT2_DW-1:0] slot2_dout,
    output logic [SLOT3_DW-1:0] slot3_dout,
    output logic [SLOT4_DW-1:0] slot4_dout,
    output logic [SLOT5_DW-1:0] slot5_dout,
    output logic [SLOT6_DW-1:0] slot6_dout,
    output logic [SLOT7_DW-1:0] slot7_dout,
    output logic [SLOT8_DW-1:0] slot8_dout,
    output logic [SLOT9_DW-1:0] slot9_dout,
    input  logic [15:0]         slot0_din,
    input  logic [15:0]         slot1_din,
    input  logic [9:0]          slot_cs,
    input  logic [9:0]          slot_wr,
    output logic [9:0]          slot_ok,
    jtframe_sdram_mux_if.master sdram
);

    localparam int c_DW [10] = '{SLOT0_DW, SLOT1_DW, SLOT2_DW, SLOT3_DW, SLOT4_DW,
                                 SLOT5_DW, SLOT6_DW, SLOT7_DW, SLOT8_DW, SLOT9_DW};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [21:0] w_offset [10];
    logic [21:0] w_addr   [10];
    logic [9:0]  w_pending;
    logic        w_any_pending;
    logic [3:0]  w_gnt;
    logic        w_grant;
    logic        w_wr_gnt;
    logic [15:0] w_din;
    logic        w_done;
    logic [3:0]  r_sel;
    logic [21:0] r_rel_addr;
    logic        r_req;
    logic        r_rnw;
    logic [21:0] r_sdram_addr;
    logic [31:0] r_data_write;

    assign w_offset[0] = slot0_offset;  assign w_addr[0] = 22'(slot0_addr);
    assign w_offset[1] = slot1_offset;  assign w_addr[1] = 22'(slot1_addr);
    assign w_offset[2] = slot2_offset;  assign w_addr[2] = 22'(slot2_addr);
    assign w_offset[3] = slot3_offset;  assign w_addr[3] = 22'(slot3_addr);
    assign w_offset[4] = slot4_offset;  assign w_addr[4] = 22'(slot4_addr);
    assign w_offset[5] = slot5_offset;  assign w_addr[5] = 22'(slot5_addr);
    assign w_offset[6] = slot6_offset;  assign w_addr[6] = 22'(slot6_addr);
    assign w_offset[7] = slot7_offset;  assign w_addr[7] = 22'(slot7_addr);
    assign w_offset[8] = slot8_offset;  assign w_addr[8] = 22'(slot8_addr);
    assign w_offset[9] = slot9_offset;  assign w_addr[9] = 22'(slot9_addr);

    assign w_pending     = slot_cs & ~slot_ok & {10{~downloading}};
    assign w_any_pending = |w_pending;
    assign w_grant       = (r_state == IDLE) && w_any_pending;
    assign w_done        = (r_state == WAIT_DATA) && sdram.data_rdy;
    assign w_wr_gnt      = ((w_gnt == 4'd0) && slot_wr[0]) || ((w_gnt == 4'd1) && slot_wr[1]);
    assign w_din         = w_gnt[0] ? slot1_din : slot0_din;

    // Lowest index wins: scanning downwards lets the last hit overwrite.
    always_comb begin
        w_gnt = 4'd0;
        for (int i = 9; i >= 0; i--) begin
            if (w_pending[i]) w_gnt = 4'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_next;
    end

    always_comb begin
        w_state_next     = r_state;
        sdram.refresh_en = 1'b0;
        unique case (r_state)
            IDLE:      if (w_grant)         w_state_next = WAIT_ACK;
            WAIT_ACK:  if (sdram.sdram_ack) w_state_next = WAIT_DATA;
            WAIT_DATA: if (sdram.data_rdy)  w_state_next = IDLE;
            default:                        w_state_next = IDLE;
        endcase
        if (loop_rst) w_state_next = IDLE;
        sdram.refresh_en = rst && (r_state == IDLE) && !w_any_pending && !downloading;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req        <= 1'b0;
            r_rnw        <= 1'b1;
            r_sdram_addr <= 22'd0;
            r_data_write <= 32'd0;
            r_sel        <= 4'd0;
            r_rel_addr   <= 22'd0;
        end else if (loop_rst) begin
            r_req <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_req        <= 1'b1;
                        r_sel        <= w_gnt;
                        r_rel_addr   <= w_addr[w_gnt];
                        r_sdram_addr <= w_offset[w_gnt] + w_addr[w_gnt];
                        r_rnw        <= ~w_wr_gnt;
                        if (w_wr_gnt) r_data_write <= {w_din, w_din};
                    end
                end
                WAIT_ACK: if (sdram.sdram_ack) r_req <= 1'b0;
                default: ;
            endcase
        end
    end

    assign sdram.sdram_req  = r_req;
    assign sdram.sdram_addr = r_sdram_addr;
    assign sdram.sdram_rnw  = r_rnw;
    assign sdram.data_write = r_data_write;

    generate
        for (genvar n = 0; n < 10; n++) begin : g_slot
            localparam int c_SLOT_DW = c_DW[n];
            logic                 r_valid;
            logic [21:0]          r_cache;
            logic [c_SLOT_DW-1:0] r_dout;
            logic                 w_mine;

            assign w_mine     = w_done && (r_sel == 4'(n));
            assign slot_ok[n] = slot_cs[n] && r_valid && !downloading && (w_addr[n] == r_cache);

            // Any completed write drops every slot's cached read; the writer then owns its entry.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_valid <= 1'b0;
                    r_cache <= 22'd0;
                    r_dout  <= '0;
                end else if (loop_rst) begin
                    r_valid <= 1'b0;
                end else if (w_done) begin
                    if (w_mine) begin
                        r_valid <= 1'b1;
                        r_cache <= r_rel_addr;
                        if (r_rnw) r_dout <= sdram.data_read[c_SLOT_DW-1:0];
                    end else if (!r_rnw) begin
                        r_valid <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign slot0_dout = g_slot[0].r_dout;
    assign slot1_dout = g_slot[1].r_dout;
    assign slot2_dout = g_slot[2].r_dout;
    assign slot3_dout = g_slot[3].r_dout;
    assign slot4_dout = g_slot[4].r_dout;
    assign slot5_dout = g_slot[5].r_dout;
    assign slot6_dout = g_slot[6].r_dout;
    assign slot7_dout = g_slot[7].r_dout;
    assign slot8_dout = g_slot[8].r_dout;
    assign slot9_dout = g_slot[9].r_dout;

    logic w_unused;
    assign w_unused = &{1'b0, vblank, slot_wr[9:2], sdram.data_read};

endmodule
`default_nettype wire

// File: tb/tb_jtframe_sdram_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtframe_sdram_mux
// Brief    : Scoreboard bench for jtframe_sdram_mux with a behavioural SDRAM
// Revision : 1.0
// ============================================================================
module tb_jtframe_sdram_mux;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, vblank, downloading, loop_rst;
    logic [21:0] off  [10];
    logic [21:0] addr [10];
    logic [15:0] din0, din1;
    logic [9:0]  cs, wr, ok;
    logic [15:0] d0, d1, d3, d4, d5, d6, d7, d8, d9;
    logic [31:0] d2;
    bit          hold_data, ack_seen;

    jtframe_sdram_mux_if sdram();

    jtframe_sdram_mux #(.SLOT3_AW(18), .SLOT2_DW(32)) dut (
        .clk(clk), .rst(rst), .vblank(vblank), .downloading(downloading), .loop_rst(loop_rst),
        .slot0_offset(off[0]), .slot1_offset(off[1]), .slot2_offset(off[2]), .slot3_offset(off[3]),
        .slot4_offset(off[4]), .slot5_offset(off[5]), .slot6_offset(off[6]), .slot7_offset(off[7]),
        .slot8_offset(off[8]), .slot9_offset(off[9]),
        .slot0_addr(addr[0]), .slot1_addr(addr[1]), .slot2_addr(addr[2]), .slot3_addr(addr[3][17:0]),
        .slot4_addr(addr[4]), .slot5_addr(addr[5]), .slot6_addr(addr[6]), .slot7_addr(addr[7]),
        .slot8_addr(addr[8]), .slot9_addr(addr[9]),
        .slot0_dout(d0), .slot1_dout(d1), .slot2_dout(d2), .slot3_dout(d3), .slot4_dout(d4),
        .slot5_dout(d5), .slot6_dout(d6), .slot7_dout(d7), .slot8_dout(d8), .slot9_dout(d9),
        .slot0_din(din0), .slot1_din(din1),
        .slot_cs(cs), .slot_ok(ok), .slot_wr(wr),
        .sdram(sdram.master)
    );

    int checks, errors;

    typedef struct { logic [21:0] a; logic rnw; logic [31:0] wd; } req_t;
    typedef struct { int slot; logic [31:0] d; bit via; } ok_t;
    req_t q_req [$];
    ok_t  q_ok  [$];
    logic [15:0] mem [logic [21:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_req(input logic [21:0] a, input logic rnw, input logic [31:0] wd);
        req_t e;
        e.a = a; e.rnw = rnw; e.wd = wd;
        q_req.push_back(e);
    endtask

    task automatic exp_ok(input int slot, input logic [31:0] d, input bit via);
        ok_t e;
        e.slot = slot; e.d = d; e.via = via;
        q_ok.push_back(e);
    endtask

    function automatic logic [15:0] rd(input logic [21:0] a);
        return mem.exists(a) ? mem[a] : 16'hDEAD;
    endfunction

    function automatic logic [31:0] dout(input int n);
        case (n)
            0: return {16'd0, d0};  1: return {16'd0, d1};  2: return d2;
            3: return {16'd0, d3};  4: return {16'd0, d4};  5: return {16'd0, d5};
            6: return {16'd0, d6};  7: return {16'd0, d7};  8: return {16'd0, d8};
            default: return {16'd0, d9};
        endcase
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((q_req.size() != 0 || q_ok.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(q_req.size() + q_ok.size()), 32'd0);
    endtask

    // Behavioural SDRAM controller: ack one cycle after req, data two cycles later.
    initial begin
        logic [21:0] ma;
        logic        mrnw;
        logic [31:0] mwd;
        sdram.sdram_ack = 1'b0;
        sdram.data_rdy  = 1'b0;
        sdram.data_read = 32'd0;
        forever begin
            @(negedge clk);
            if (sdram.sdram_req === 1'b1 && rst) begin
                ma = sdram.sdram_addr; mrnw = sdram.sdram_rnw; mwd = sdram.data_write;
                @(negedge clk); sdram.sdram_ack = 1'b1;
                @(negedge clk); sdram.sdram_ack = 1'b0; ack_seen = 1'b1;
                repeat (2) @(negedge clk);
                while (hold_data) @(negedge clk);
                if (!mrnw) mem[ma] = mwd[15:0];
                sdram.data_read = {rd(ma + 22'd1), rd(ma)};
                sdram.data_rdy  = 1'b1;
                @(negedge clk); sdram.data_rdy = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard on every new request and every rising slot_ok.
    initial begin
        logic       req_q, rdy_q;
        logic [9:0] ok_q;
        req_t       er;
        ok_t        eo;
        req_q = 1'b0; rdy_q = 1'b0; ok_q = 10'd0;
        forever begin
            @(negedge clk); #1;
            if (sdram.sdram_req === 1'b1 && !req_q) begin
                if (q_req.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: got request at %h, expected none", sdram.sdram_addr);
                end else begin
                    er = q_req.pop_front();
                    check("req_addr", 32'(sdram.sdram_addr), 32'(er.a));
                    check("req_rnw", 32'(sdram.sdram_rnw), 32'(er.rnw));
                    if (!er.rnw) check("req_wdata", sdram.data_write, er.wd);
                end
            end
            for (int n = 0; n < 10; n++) begin
                if (ok[n] === 1'b1 && !ok_q[n]) begin
                    if (q_ok.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_ok: got slot_ok[%0d], expected none", n);
                    end else begin
                        eo = q_ok.pop_front();
                        check("ok_slot", 32'(n), 32'(eo.slot));
                        check("ok_dout", dout(n), eo.d);
                        if (eo.via) check("ok_latency", 32'(rdy_q), 32'd1);
                    end
                end
            end
            req_q = sdram.sdram_req;
            ok_q  = ok;
            rdy_q = sdram.data_rdy;
        end
    end

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; vblank = 1'b0; downloading = 1'b0; loop_rst = 1'b0;
        cs = 10'd0; wr = 10'd0; din0 = 16'd0; din1 = 16'd0;
        hold_data = 1'b0; ack_seen = 1'b0;
        for (int n = 0; n < 10; n++) begin off[n] = 22'd0; addr[n] = 22'd0; end
        off[3] = 22'h320000; addr[3] = 22'h00010;
        off[2] = 22'h100000; addr[2] = 22'h00040;
        off[6] = 22'h200000; addr[6] = 22'h00007;
        off[7] = 22'h3FFFF0; addr[7] = 22'h00057;
        addr[0] = 22'h5; addr[4] = 22'h44; addr[5] = 22'h45; addr[8] = 22'h48; addr[9] = 22'h49;
        mem[22'h320010] = 16'hBEEF; mem[22'h320011] = 16'h0BAD;
        mem[22'h100040] = 16'h1111; mem[22'h100041] = 16'h2222;
        mem[22'h200007] = 16'hCAFE;
        mem[22'h000044] = 16'h4444; mem[22'h000045] = 16'h5555; mem[22'h000047] = 16'h7777;
        mem[22'h000048] = 16'h8888; mem[22'h000049] = 16'h9999;

        repeat (3) @(negedge clk); #1;
        check("rst_req", 32'(sdram.sdram_req), 32'd0);
        check("rst_rnw", 32'(sdram.sdram_rnw), 32'd1);
        check("rst_addr", 32'(sdram.sdram_addr), 32'd0);
        check("rst_wdata", sdram.data_write, 32'd0);
        check("rst_refresh", 32'(sdram.refresh_en), 32'd0);
        check("rst_ok", 32'(ok), 32'd0);
        check("rst_dout3", dout(3), 32'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1 check("idle_refresh", 32'(sdram.refresh_en), 32'd1);

        // Slot 3 read, then cache hit with cs toggled
        @(negedge clk);
        exp_req(22'h320010, 1'b1, 32'd0); exp_ok(3, 32'h0000BEEF, 1'b1);
        cs[3] = 1'b1;
        drain("slot3_read");
        @(negedge clk); cs[3] = 1'b0;
        #1 check("hit_cs_low", 32'(ok[3]), 32'd0);
        @(negedge clk); exp_ok(3, 32'h0000BEEF, 1'b0); cs[3] = 1'b1;
        #1 check("hit_same_cycle", 32'(ok[3]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1 check("hit_no_req", 32'(sdram.sdram_req), 32'd0);
        end
        drain("hit");
        @(negedge clk);
        exp_req(22'h320011, 1'b1, 32'd0); exp_ok(3, 32'h00000BAD, 1'b1);
        addr[3] = 22'h00011;
        #1 check("addr_change_drop", 32'(ok[3]), 32'd0);
        drain("slot3_miss");
        @(negedge clk); cs[3] = 1'b0;

        // Slots 6 and 2 in the same cycle
        @(negedge clk);
        exp_req(22'h100040, 1'b1, 32'd0); exp_req(22'h200007, 1'b1, 32'd0);
        exp_ok(2, 32'h22221111, 1'b1);    exp_ok(6, 32'h0000CAFE, 1'b1);
        cs[2] = 1'b1; cs[6] = 1'b1;
        drain("prio_2_6");
        @(negedge clk); cs = 10'd0;

        // Slot 0 write, then slot 3 cached address must go back to SDRAM
        @(negedge clk);
        exp_req(22'h000005, 1'b0, 32'h12341234); exp_ok(0, 32'd0, 1'b1);
        din0 = 16'h1234; wr[0] = 1'b1; cs[0] = 1'b1;
        drain("slot0_write");
        @(negedge clk); cs[0] = 1'b0; wr[0] = 1'b0;
        @(negedge clk);
        exp_req(22'h320011, 1'b1, 32'd0); exp_ok(3, 32'h00000BAD, 1'b1);
        cs[3] = 1'b1;
        drain("reread_after_write");
        @(negedge clk); cs[3] = 1'b0;

        // Download blocks grants and slot_ok
        @(negedge clk); downloading = 1'b1; cs = 10'h3F8;
        for (int i = 0; i < 4; i++) begin
            repeat (5) @(negedge clk); #1;
            check("dl_req", 32'(sdram.sdram_req), 32'd0);
            check("dl_ok", 32'(ok), 32'd0);
        end
        check("dl_refresh", 32'(sdram.refresh_en), 32'd0);
        @(negedge clk);
        exp_ok(3, 32'h00000BAD, 1'b0);
        exp_req(22'h000044, 1'b1, 32'd0); exp_req(22'h000045, 1'b1, 32'd0);
        exp_req(22'h200007, 1'b1, 32'd0); exp_req(22'h000047, 1'b1, 32'd0);
        exp_req(22'h000048, 1'b1, 32'd0); exp_req(22'h000049, 1'b1, 32'd0);
        exp_ok(4, 32'h4444, 1'b1); exp_ok(5, 32'h5555, 1'b1); exp_ok(6, 32'hCAFE, 1'b1);
        exp_ok(7, 32'h7777, 1'b1); exp_ok(8, 32'h8888, 1'b1); exp_ok(9, 32'h9999, 1'b1);
        downloading = 1'b0;
        drain("dl_resume");
        @(negedge clk); cs = 10'd0;

        // loop_rst clears the caches
        @(negedge clk); loop_rst = 1'b1;
        @(negedge clk); loop_rst = 1'b0;
        exp_req(22'h000044, 1'b1, 32'd0); exp_ok(4, 32'h4444, 1'b1);
        cs[4] = 1'b1;
        drain("loop_rst_reread");
        @(negedge clk); cs = 10'd0;

        // Reset while waiting for data
        @(negedge clk); hold_data = 1'b1; ack_seen = 1'b0;
        exp_req(22'h000045, 1'b1, 32'd0);
        cs[5] = 1'b1;
        for (int i = 0; i < 50 && !ack_seen; i++) @(negedge clk);
        check("reach_wait_data", 32'(ack_seen), 32'd1);
        @(negedge clk); rst = 1'b0;
        #1;
        check("mid_rst_req", 32'(sdram.sdram_req), 32'd0);
        check("mid_rst_rnw", 32'(sdram.sdram_rnw), 32'd1);
        check("mid_rst_addr", 32'(sdram.sdram_addr), 32'd0);
        check("mid_rst_wdata", sdram.data_write, 32'd0);
        check("mid_rst_refresh", 32'(sdram.refresh_en), 32'd0);
        check("mid_rst_ok", 32'(ok), 32'd0);
        check("mid_rst_dout2", dout(2), 32'd0);
        check("mid_rst_dout6", dout(6), 32'd0);
        @(negedge clk); cs = 10'd0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); hold_data = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (2) @(negedge clk); #1;
            check("late_rdy_ok", 32'(ok), 32'd0);
            check("late_rdy_req", 32'(sdram.sdram_req), 32'd0);
        end
        check("late_rdy_dout5", dout(5), 32'd0);
        @(negedge clk);
        exp_req(22'h000045, 1'b1, 32'd0); exp_ok(5, 32'h5555, 1'b1);
        cs[5] = 1'b1;
        drain("post_rst_read");
        @(negedge clk); cs = 10'd0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
